// File: rtl/ex_mem_stage_pkg.sv
// Shared EX/MEM encodings: memory access sizes, branch kinds and default widths.
// Imported by the stage, its interface and the store aligner.
package ex_mem_stage_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_RADDR_W = 5;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;

    // Encoding 3 falls through to "not taken", matching BR_NONE.
    function automatic logic branch_cond(input logic [1:0] branch_type, input logic alu_zero);
        return ((branch_type == BR_BEQ) &&  alu_zero) ||
               ((branch_type == BR_BNE) && !alu_zero);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM pipeline register.
// The stage uses the slave modport; the surrounding core (or bench) uses master.
interface ex_mem_stage_if #(
    parameter int XLEN    = ex_mem_stage_pkg::DEF_XLEN,
    parameter int RADDR_W = ex_mem_stage_pkg::DEF_RADDR_W
);
    logic               in_valid;
    logic               stall;
    logic               flush_in;
    logic [XLEN-1:0]    alu_out;
    logic               alu_zero;
    logic [XLEN-1:0]    rt_data;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [1:0]         mem_size;
    logic [1:0]         branch_type;
    logic [XLEN-1:0]    branch_target;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;

    logic               out_valid;
    logic [XLEN-1:0]    out_alu_result;
    logic [XLEN-1:0]    out_store_data;
    logic [3:0]         out_byte_en;
    logic [RADDR_W-1:0] out_rd;
    logic               out_reg_write;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_misaligned;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               hazard_stall;

    modport slave (
        input  in_valid, stall, flush_in, alu_out, alu_zero, rt_data, rd_addr,
               reg_write, mem_read, mem_write, mem_size, branch_type, branch_target,
               id_rs, id_rt,
        output out_valid, out_alu_result, out_store_data, out_byte_en, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_misaligned,
               redirect_valid, redirect_pc, hazard_stall
    );

    modport master (
        output in_valid, stall, flush_in, alu_out, alu_zero, rt_data, rd_addr,
               reg_write, mem_read, mem_write, mem_size, branch_type, branch_target,
               id_rs, id_rt,
        input  out_valid, out_alu_result, out_store_data, out_byte_en, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_misaligned,
               redirect_valid, redirect_pc, hazard_stall
    );

endinterface

// File: rtl/ex_mem_stage_store_align.sv
// Combinational store aligner: byte lanes, lane-replicated store data and the
// misalignment flag for a data-memory access at addr[1:0].
module ex_mem_stage_store_align
    import ex_mem_stage_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [1:0]      addr,
    input  logic [1:0]      mem_size,
    input  logic [XLEN-1:0] rt_data,
    input  logic            rd,
    input  logic            wr,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] store_data,
    output logic            misaligned
);

    logic [3:0] lanes;
    logic       bad_align;
    logic       mem_op;

    assign mem_op = rd | wr;

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        lanes      = 4'b1111;
        store_data = rt_data;
        bad_align  = 1'b0;
        case (mem_size)
            MEM_BYTE: begin
                lanes      = 4'b0001 << addr;
                store_data = {(XLEN/8){rt_data[7:0]}};
            end
            MEM_HALF: begin
                lanes      = addr[1] ? 4'b1100 : 4'b0011;
                store_data = {(XLEN/16){rt_data[15:0]}};
                bad_align  = addr[0];
            end
            default: begin
                lanes     = 4'b1111;
                bad_align = |addr;
            end
        endcase
    end

    assign misaligned = mem_op & bad_align;
    assign byte_en    = (mem_op && !misaligned) ? lanes : 4'b0000;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results and controls, aligns stores,
// resolves BEQ/BNE into a one-cycle redirect with wrong-path squash, flags load-use.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RADDR_W = DEF_RADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_stage_if.slave bus
);

    logic               valid_q;
    logic [XLEN-1:0]    alu_result_q;
    logic [XLEN-1:0]    store_data_q;
    logic [3:0]         byte_en_q;
    logic [RADDR_W-1:0] rd_q;
    logic               reg_write_q;
    logic               mem_read_q;
    logic               mem_write_q;
    logic               misaligned_q;
    logic               redirect_valid_q;
    logic [XLEN-1:0]    redirect_pc_q;
    logic               squash_pending;

    logic [3:0]         al_byte_en;
    logic [XLEN-1:0]    al_store_data;
    logic               al_misaligned;
    logic               load_cond;
    logic               taken;

    ex_mem_stage_store_align #(.XLEN(XLEN)) u_store_align (
        .addr       (bus.alu_out[1:0]),
        .mem_size   (bus.mem_size),
        .rt_data    (bus.rt_data),
        .rd         (bus.mem_read),
        .wr         (bus.mem_write),
        .byte_en    (al_byte_en),
        .store_data (al_store_data),
        .misaligned (al_misaligned)
    );

    assign load_cond = bus.in_valid & ~bus.flush_in & ~bus.stall & ~squash_pending;
    assign taken     = load_cond & branch_cond(bus.branch_type, bus.alu_zero);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q          <= 1'b0;
            alu_result_q     <= '0;
            store_data_q     <= '0;
            byte_en_q        <= '0;
            rd_q             <= '0;
            reg_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            misaligned_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            squash_pending   <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            if (bus.flush_in || (!bus.stall && (squash_pending || !bus.in_valid))) begin
                // Bubble: only side-effect controls are cleared, data is don't-care.
                valid_q        <= 1'b0;
                reg_write_q    <= 1'b0;
                mem_read_q     <= 1'b0;
                mem_write_q    <= 1'b0;
                byte_en_q      <= 4'b0000;
                misaligned_q   <= 1'b0;
                squash_pending <= 1'b0;
            end else if (load_cond) begin
                valid_q        <= 1'b1;
                alu_result_q   <= bus.alu_out;
                store_data_q   <= al_store_data;
                byte_en_q      <= al_byte_en;
                rd_q           <= bus.rd_addr;
                reg_write_q    <= bus.reg_write;
                mem_read_q     <= bus.mem_read & ~al_misaligned;
                mem_write_q    <= bus.mem_write & ~al_misaligned;
                misaligned_q   <= al_misaligned;
                if (taken) begin
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= bus.branch_target;
                    squash_pending   <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_alu_result = alu_result_q;
    assign bus.out_store_data = store_data_q;
    assign bus.out_byte_en    = byte_en_q;
    assign bus.out_rd         = rd_q;
    assign bus.out_reg_write  = reg_write_q;
    assign bus.out_mem_read   = mem_read_q;
    assign bus.out_mem_write  = mem_write_q;
    assign bus.out_misaligned = misaligned_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

    assign bus.hazard_stall = valid_q & mem_read_q & (rd_q != '0) &
                              ((rd_q == bus.id_rs) | (rd_q == bus.id_rt));

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_stage_if bus ();
    ex_mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic        m_valid, m_rw, m_mr, m_mw, m_mis, m_rv, m_sq;
    logic [31:0] m_alu, m_sd, m_rpc;
    logic [3:0]  m_be;
    logic [4:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mis = 0; m_rv = 0; m_sq = 0;
        m_alu = 0; m_sd = 0; m_rpc = 0; m_be = 0; m_rd = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_be = 0; m_mis = 0; m_sq = 0;
    endtask

    // Next MEM-stage contents, computed from the current inputs before the edge.
    task automatic model_edge();
        int    sz, nb, shamt;
        logic  memop, taken;
        m_rv = 0;
        if (bus.flush_in) model_bubble();
        else if (bus.stall) ;
        else if (m_sq || !bus.in_valid) model_bubble();
        else begin
            sz    = (bus.mem_size == 2'd3) ? 2 : int'(bus.mem_size);
            nb    = 1 << sz;
            memop = bus.mem_read | bus.mem_write;
            m_mis = memop && ((bus.alu_out % nb) != 0);
            shamt = int'(bus.alu_out[1:0]) & (4 - nb);
            m_be  = (memop && !m_mis) ? 4'(((1 << nb) - 1) << shamt) : 4'd0;
            m_sd  = (nb == 4) ? bus.rt_data :
                    (nb == 2) ? (bus.rt_data & 32'hFFFF) * 32'h0001_0001 :
                                (bus.rt_data & 32'hFF) * 32'h0101_0101;
            m_valid = 1;
            m_alu   = bus.alu_out;
            m_rd    = bus.rd_addr;
            m_rw    = bus.reg_write;
            m_mr    = bus.mem_read & !m_mis;
            m_mw    = bus.mem_write & !m_mis;
            taken   = (bus.branch_type == 2'd1 && bus.alu_zero) ||
                      (bus.branch_type == 2'd2 && !bus.alu_zero);
            if (taken) begin
                m_rv = 1; m_rpc = bus.branch_target; m_sq = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic hz;
        hz = m_valid && m_mr && (m_rd != 0) && (m_rd == bus.id_rs || m_rd == bus.id_rt);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".rv"},    32'(bus.redirect_valid), 32'(m_rv));
        chk({tag, ".rw"},    32'(bus.out_reg_write), 32'(m_rw));
        chk({tag, ".mr"},    32'(bus.out_mem_read), 32'(m_mr));
        chk({tag, ".mw"},    32'(bus.out_mem_write), 32'(m_mw));
        chk({tag, ".be"},    32'(bus.out_byte_en), 32'(m_be));
        chk({tag, ".mis"},   32'(bus.out_misaligned), 32'(m_mis));
        chk({tag, ".hz"},    32'(bus.hazard_stall), 32'(hz));
        if (m_rv) chk({tag, ".rpc"}, bus.redirect_pc, m_rpc);
        if (m_valid) begin
            chk({tag, ".alu"}, bus.out_alu_result, m_alu);
            chk({tag, ".rd"},  32'(bus.out_rd), 32'(m_rd));
            chk({tag, ".sd"},  bus.out_store_data, m_sd);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic ins(input logic v, input logic [31:0] alu, input logic z,
                       input logic [31:0] rt, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic [1:0] sz,
                       input logic [1:0] bt, input logic [31:0] tgt);
        bus.in_valid = v;  bus.alu_out = alu; bus.alu_zero = z; bus.rt_data = rt;
        bus.rd_addr = rd;  bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw;
        bus.mem_size = sz; bus.branch_type = bt; bus.branch_target = tgt;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".alu"},   bus.out_alu_result, 32'd0);
        chk({tag, ".sd"},    bus.out_store_data, 32'd0);
        chk({tag, ".be"},    32'(bus.out_byte_en), 32'd0);
        chk({tag, ".rd"},    32'(bus.out_rd), 32'd0);
        chk({tag, ".rw"},    32'(bus.out_reg_write), 32'd0);
        chk({tag, ".mr"},    32'(bus.out_mem_read), 32'd0);
        chk({tag, ".mw"},    32'(bus.out_mem_write), 32'd0);
        chk({tag, ".mis"},   32'(bus.out_misaligned), 32'd0);
        chk({tag, ".rv"},    32'(bus.redirect_valid), 32'd0);
        chk({tag, ".rpc"},   bus.redirect_pc, 32'd0);
        chk({tag, ".hz"},    32'(bus.hazard_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 0; bus.flush_in = 0; bus.id_rs = 0; bus.id_rt = 0;
        ins(0, 0, 0, 0, 0, 0, 0, 0, MEM_WORD, BR_NONE, 0);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();

        // Reset asserted between edges clears outputs without a clock.
        ins(1, 32'h1000, 0, 32'h1234_5678, 0, 0, 0, 1, MEM_WORD, BR_NONE, 0);
        step("sw_pre");
        chk("sw_pre.be_const", 32'(bus.out_byte_en), 32'hF);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        #1 rst = 1'b0;
        model_reset();
        ins(0, 0, 0, 0, 0, 0, 0, 0, MEM_WORD, BR_NONE, 0);
        step("post_rst");

        // BEQ taken, wrong-path ADDU squashed.
        ins(1, 0, 1, 0, 0, 0, 0, 0, MEM_WORD, BR_BEQ, 32'h0040_0020);
        step("beq");
        chk("beq.rv_const", 32'(bus.redirect_valid), 32'd1);
        chk("beq.rpc_const", bus.redirect_pc, 32'h0040_0020);
        ins(1, 32'h55, 0, 0, 5'd3, 1, 0, 0, MEM_WORD, BR_NONE, 0);
        step("beq_sq");
        chk("beq_sq.valid_const", 32'(bus.out_valid), 32'd0);
        chk("beq_sq.rv_const", 32'(bus.redirect_valid), 32'd0);
        ins(1, 32'h66, 0, 0, 5'd4, 1, 0, 0, MEM_WORD, BR_NONE, 0);
        step("beq_next");

        // BNE with zero set does not redirect.
        ins(1, 0, 1, 0, 0, 0, 0, 0, MEM_WORD, BR_BNE, 32'h0040_0100);
        step("bne");
        chk("bne.rv_const", 32'(bus.redirect_valid), 32'd0);
        ins(1, 32'h77, 0, 0, 5'd6, 1, 0, 0, MEM_WORD, BR_NONE, 0);
        step("bne_next");

        // Taken branch then 3-cycle stall: squash waits for the release.
        ins(1, 0, 1, 0, 0, 0, 0, 0, MEM_WORD, BR_BEQ, 32'h0040_0200);
        step("stl_br");
        ins(1, 32'h88, 0, 0, 5'd8, 1, 0, 0, MEM_WORD, BR_NONE, 0);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) step("stl_hold");
        chk("stl_hold.rv_const", 32'(bus.redirect_valid), 32'd0);
        bus.stall = 0;
        step("stl_rel");
        chk("stl_rel.valid_const", 32'(bus.out_valid), 32'd0);
        ins(1, 32'h99, 0, 0, 5'd9, 1, 0, 0, MEM_WORD, BR_NONE, 0);
        step("stl_next");

        // Store alignment.
        ins(1, 32'h1003, 0, 32'hAABB_CCDD, 0, 0, 0, 1, MEM_BYTE, BR_NONE, 0);
        step("sb");
        chk("sb.be_const", 32'(bus.out_byte_en), 32'h8);
        chk("sb.sd_const", bus.out_store_data, 32'hDDDD_DDDD);
        ins(1, 32'h1001, 0, 32'hAABB_CCDD, 0, 0, 0, 1, MEM_HALF, BR_NONE, 0);
        step("sh_mis");
        chk("sh_mis.mis_const", 32'(bus.out_misaligned), 32'd1);
        chk("sh_mis.mw_const", 32'(bus.out_mem_write), 32'd0);
        ins(1, 32'h1000, 0, 32'hAABB_CCDD, 0, 0, 0, 1, MEM_WORD, BR_NONE, 0);
        step("sw");
        chk("sw.be_const", 32'(bus.out_byte_en), 32'hF);

        // Load-use hazard.
        ins(1, 32'h2000, 0, 0, 5'd5, 1, 1, 0, MEM_WORD, BR_NONE, 0);
        step("lw5");
        bus.id_rs = 5; bus.id_rt = 0;
        #1 chk("hz_rs", 32'(bus.hazard_stall), 32'd1);
        bus.id_rs = 0; bus.id_rt = 5;
        #1 chk("hz_rt", 32'(bus.hazard_stall), 32'd1);
        bus.id_rs = 0; bus.id_rt = 0;
        ins(1, 32'h2000, 0, 0, 5'd0, 1, 1, 0, MEM_WORD, BR_NONE, 0);
        step("lw0");
        chk("hz_r0", 32'(bus.hazard_stall), 32'd0);
        bus.id_rs = 5;
        ins(1, 32'h10, 0, 0, 5'd5, 1, 0, 0, MEM_WORD, BR_NONE, 0);
        step("addu5");
        chk("hz_addu", 32'(bus.hazard_stall), 32'd0);
        bus.id_rs = 0;

        // Flush + stall with a pending squash and a taken BEQ in EX.
        ins(1, 0, 1, 0, 0, 0, 0, 0, MEM_WORD, BR_BEQ, 32'h0040_0300);
        step("fl_br");
        ins(1, 0, 1, 0, 0, 0, 0, 0, MEM_WORD, BR_BEQ, 32'h0040_0400);
        bus.flush_in = 1; bus.stall = 1;
        step("fl_st");
        chk("fl_st.valid_const", 32'(bus.out_valid), 32'd0);
        chk("fl_st.rv_const", 32'(bus.redirect_valid), 32'd0);
        bus.flush_in = 0; bus.stall = 0;
        ins(1, 32'hAB, 0, 0, 5'd10, 1, 0, 0, MEM_WORD, BR_NONE, 0);
        step("fl_next");
        chk("fl_next.valid_const", 32'(bus.out_valid), 32'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ins(($urandom % 8) != 0, $urandom, $urandom % 2, $urandom,
                5'($urandom % 8), $urandom % 2, $urandom % 3 == 0, $urandom % 3 == 0,
                2'($urandom % 4), 2'($urandom % 4), $urandom);
            bus.stall    = ($urandom % 8) == 0;
            bus.flush_in = ($urandom % 16) == 0;
            bus.id_rs    = 5'($urandom % 8);
            bus.id_rt    = 5'($urandom % 8);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register for the MIPS150 core, directly downstream of the ALU.
- Captures the ALU result and zero flag, plus store data and control, and resolves BEQ/BNE into a registered redirect with wrong-path squash.
- Generates byte enables, aligned store data and a misalignment flag for the data memory.
- Detects load-use hazards against the instruction in decode.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register-address width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX holds a real instruction
- stall  in  1  hold all stage state
- flush_in  in  1  kill the EX instruction (exception/external)
- alu_out  in  XLEN  ALU result; also the memory address
- alu_zero  in  1  ALU zero flag
- rt_data  in  XLEN  raw store data
- rd_addr  in  RADDR_W  destination register
- reg_write, mem_read, mem_write  in  1 each  control
- mem_size  in  2  BYTE=0, HALF=1, WORD=2; 3 is illegal and treated as WORD
- branch_type  in  2  NONE=0, BEQ=1, BNE=2; 3 is treated as NONE
- branch_target  in  XLEN  resolved target PC
- id_rs, id_rt  in  RADDR_W  source registers of the decode-stage instruction
- out_valid  out  1  MEM-stage instruction valid
- out_alu_result  out  XLEN
- out_store_data  out  XLEN  lane-replicated store data
- out_byte_en  out  4
- out_rd  out  RADDR_W
- out_reg_write, out_mem_read, out_mem_write  out  1 each
- out_misaligned  out  1
- redirect_valid  out  1  one-cycle taken-branch pulse
- redirect_pc  out  XLEN
- hazard_stall  out  1  combinational load-use stall request

Behaviour:
- Reset (async, rst=1): every registered output is 0, and squash_pending is 0. hazard_stall reads 0 because out_valid is 0.
- Capture rule: applies on each rising clk. Priority is flush_in, then stall, then squash_pending, then load.
  - flush_in=1 inserts a bubble: out_valid and all side-effect controls go to 0, data registers don't care. flush_in also clears squash_pending and suppresses branch evaluation. flush beats stall.
  - stall=1 (no flush) holds every register, including squash_pending. redirect_valid drops to 0 after its single cycle.
  - squash_pending=1 (no stall) inserts a bubble and clears squash_pending.
  - in_valid=0 inserts a bubble.
  - Otherwise all fields load, with latency 1.
- Branch: taken = load_condition & ((BEQ & alu_zero) | (BNE & ~alu_zero)).
  - When taken, on the next edge: redirect_valid=1, redirect_pc=branch_target, squash_pending=1.
  - redirect_valid is high for exactly one cycle.
  - The instruction present in EX in the following non-stalled capture is the wrong path and is squashed.
  - A branch that is itself squashed or flushed never redirects.
- Memory alignment, computed from alu_out[1:0] at capture:
  - BYTE: byte_en = 4'b0001 << a[1:0]; store_data = {4{rt[7:0]}}.
  - HALF: byte_en = a[1] ? 4'b1100 : 4'b0011; store_data = {2{rt[15:0]}}; misaligned if a[0].
  - WORD: byte_en = 4'b1111; store_data = rt; misaligned if a[1:0] != 0.
  - byte_en is 0 when neither mem_read nor mem_write is set.
  - When misaligned: out_misaligned=1, out_mem_write and out_mem_read are forced to 0, and byte_en is 0.
  - out_misaligned is only set for valid memory operations.
- Hazard: hazard_stall = out_valid & out_mem_read & (out_rd != 0) & ((out_rd == id_rs) | (out_rd == id_rt)). It is purely combinational from registered state.
- Register 0: the stage passes out_rd=0 with reg_write unchanged. The regfile ignores the write.

Decomposition:
- Shared header (alongside the ALU op header): MEM_BYTE/HALF/WORD and BR_NONE/BEQ/BNE encodings.
- Sub-module store_align: combinational; takes addr[1:0], mem_size, rt_data and rd/wr; produces byte_en, store_data and misaligned. It is instantiated on the capture path.

Test Plan:
- Reset mid-operation: load a valid SW, assert rst between edges. All outputs read 0 immediately, without waiting for clk.
- BEQ taken: alu_zero=1, branch_target=0x00400020, next instruction ADDU rd=3.
  - Cycle+1: redirect_valid=1, redirect_pc=0x00400020.
  - Cycle+2: out_valid=0 (squashed), redirect_valid=0.
  - BNE with alu_zero=1 produces no redirect.
- Taken branch then stall for 3 cycles: squash_pending holds and redirect_valid is high only in the first cycle. The first capture after the stall releases is a bubble; the next captures normally.
- SB at alu_out=0x1003, rt=0xAABBCCDD: byte_en=1000, store_data=0xDDDDDDDD.
  - SH at 0x1001 gives out_misaligned=1 and out_mem_write=0.
  - SW at 0x1000 gives byte_en=1111.
- Load-use: LW rd=5 in MEM, id_rs=5 gives hazard_stall=1. id_rt=5 also gives 1. rd=0 with id_rs=0 gives 0, and an ADDU rd=5 gives 0.
- Flush and stall in the same cycle as a taken BEQ: bubble inserted, no redirect, squash_pending=0.
